// File: rtl/mac_result_unloader_pkg.sv
// Shared constants, state encoding and index helper for the MAC result unloader.
package mac_result_unloader_pkg;

    localparam int DATA_W     = 4;
    localparam int RES_W      = 10;
    localparam int MAC_NUM    = 9;
    localparam int CLIP_LIMIT = 255;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Row-major position of a (row, col) pair inside the 3x3 accumulator grid.
    function automatic logic [3:0] mac_index(input logic [1:0] row, input logic [1:0] col);
        return ({2'b00, row} * 4'd3) + {2'b00, col};
    endfunction

endpackage

// File: rtl/mac_result_unloader_if.sv
// Result stream bundle: data, matrix coordinates, last marker and valid/ready handshake.
// With UNLOAD_CLIP_EN defined the bundle also carries the res_ovf clip flag.
interface mac_result_unloader_if;
    import mac_result_unloader_pkg::*;

    logic [RES_W-1:0] res_data;
    logic [1:0]       res_row;
    logic [1:0]       res_col;
    logic             res_valid;
    logic             res_last;
    logic             res_ready;
`ifdef UNLOAD_CLIP_EN
    logic             res_ovf;

    modport master (
        output res_data, res_row, res_col, res_valid, res_last, res_ovf,
        input  res_ready
    );

    modport slave (
        input  res_data, res_row, res_col, res_valid, res_last, res_ovf,
        output res_ready
    );
`else
    modport master (
        output res_data, res_row, res_col, res_valid, res_last,
        input  res_ready
    );

    modport slave (
        input  res_data, res_row, res_col, res_valid, res_last,
        output res_ready
    );
`endif

endinterface

// File: rtl/mac_result_unloader_res_index_counter.sv
// Row/column walker over a row_w x col_x result matrix in row-major order.
// Exposes the following position so the parent can pre-register the next beat.
module res_index_counter (
    input  logic       clk,
    input  logic       clear_n,
    input  logic       load,
    input  logic       advance,
    input  logic [1:0] row_w,
    input  logic [1:0] col_x,
    output logic [1:0] row,
    output logic [1:0] col,
    output logic [1:0] next_row,
    output logic [1:0] next_col,
    output logic       last
);

    logic [1:0] row_reg;
    logic [1:0] col_reg;
    logic       col_end;
    logic       row_end;

    // Wrap decode and next position.
    always_comb begin
        col_end  = (col_reg == (col_x - 2'd1));
        row_end  = (row_reg == (row_w - 2'd1));
        next_col = col_end ? 2'd0 : (col_reg + 2'd1);
        next_row = row_reg;
        if (col_end) begin
            next_row = row_end ? 2'd0 : (row_reg + 2'd1);
        end
    end

    // Position register: cleared on reset and on a new capture, steps on each transfer.
    always_ff @(posedge clk) begin
        if (!clear_n || load) begin
            row_reg <= 2'd0;
            col_reg <= 2'd0;
        end else if (advance) begin
            row_reg <= next_row;
            col_reg <= next_col;
        end
    end

    assign row  = row_reg;
    assign col  = col_reg;
    assign last = col_end && row_end;

endmodule

// File: rtl/mac_result_unloader.sv
// Captures the nine MAC accumulators on a rising edge of unload_res and streams the
// row_w x col_x valid results out one per handshake in row-major order.
// Optional feature macro: UNLOAD_CLIP_EN (saturate beats to 255 and flag res_ovf).
module mac_result_unloader
    import mac_result_unloader_pkg::*;
(
    input  logic                     clk,
    input  logic                     clear_n,
    input  logic [MAC_NUM*RES_W-1:0] mac_res,
    input  logic                     unload_res,
    input  logic [1:0]               row_w,
    input  logic [1:0]               col_x,
    output logic                     busy,
    output logic                     done,
    mac_result_unloader_if.master    res
);

    state_t           state_reg;
    state_t           state_next;
    logic             unload_prev_reg;
    logic [1:0]       row_w_reg;
    logic [1:0]       col_x_reg;
    logic [RES_W-1:0] buf_mem [MAC_NUM];

    logic [RES_W-1:0] res_data_reg;
    logic             res_valid_reg;
    logic             busy_reg;
    logic             done_reg;

    logic             rise;
    logic             xfer;
    logic             capture;
    logic             advance;
    logic [1:0]       idx_next_row;
    logic [1:0]       idx_next_col;
    logic             idx_last;
    logic [RES_W-1:0] beat_word;
    logic [RES_W-1:0] beat_out;

    res_index_counter u_index (
        .clk      (clk),
        .clear_n  (clear_n),
        .load     (capture),
        .advance  (advance),
        .row_w    (row_w_reg),
        .col_x    (col_x_reg),
        .row      (res.res_row),
        .col      (res.res_col),
        .next_row (idx_next_row),
        .next_col (idx_next_col),
        .last     (idx_last)
    );

    // Next state plus capture/advance strobes; unload_res edges only count in IDLE.
    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        advance    = 1'b0;
        rise       = unload_res && !unload_prev_reg;
        xfer       = res_valid_reg && res.res_ready;
        case (state_reg)
            IDLE: begin
                if (rise) begin
                    capture    = 1'b1;
                    state_next = ((row_w == 2'd0) || (col_x == 2'd0)) ? DONE : STREAM;
                end
            end
            STREAM: begin
                if (xfer) begin
                    if (idx_last) begin
                        state_next = DONE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The first beat bypasses the buffer since it is being written in the same cycle.
    always_comb begin
        beat_word = capture ? mac_res[RES_W-1:0]
                            : buf_mem[mac_index(idx_next_row, idx_next_col)];
`ifdef UNLOAD_CLIP_EN
        beat_out  = (beat_word > RES_W'(CLIP_LIMIT)) ? RES_W'(CLIP_LIMIT) : beat_word;
`else
        beat_out  = beat_word;
`endif
    end

    // State register and previous-unload_res register for edge detection.
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state_reg       <= IDLE;
            unload_prev_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            unload_prev_reg <= unload_res;
        end
    end

    // Result buffer and job dimensions, written only at capture and frozen otherwise.
    always_ff @(posedge clk) begin
        if (capture) begin
            row_w_reg <= row_w;
            col_x_reg <= col_x;
            for (int i = 0; i < MAC_NUM; i++) begin
                buf_mem[i] <= mac_res[i*RES_W +: RES_W];
            end
        end
    end

    // Registered stream outputs; data only moves when a new beat is loaded.
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            res_data_reg  <= '0;
            res_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            res_valid_reg <= (state_next == STREAM);
            busy_reg      <= (state_next != IDLE);
            done_reg      <= (state_next == DONE);
            if (capture || advance) begin
                res_data_reg <= beat_out;
            end
        end
    end

`ifdef UNLOAD_CLIP_EN
    logic res_ovf_reg;

    // Overflow flag travels with the beat it describes and drops when streaming stops.
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            res_ovf_reg <= 1'b0;
        end else if (state_next != STREAM) begin
            res_ovf_reg <= 1'b0;
        end else if (capture || advance) begin
            res_ovf_reg <= (beat_word > RES_W'(CLIP_LIMIT));
        end
    end

    assign res.res_ovf = res_ovf_reg;
`endif

    assign res.res_data  = res_data_reg;
    assign res.res_valid = res_valid_reg;
    assign res.res_last  = res_valid_reg && idx_last;
    assign busy          = busy_reg;
    assign done          = done_reg;

endmodule

// File: tb/tb_mac_result_unloader.sv
// Scoreboard bench for mac_result_unloader: jobs push expected beats into a queue,
// a negedge monitor pops and compares every transferred beat and every done pulse.
`timescale 1ns/1ps
module tb_mac_result_unloader;
    import mac_result_unloader_pkg::*;

    typedef struct {
        int data;
        int row;
        int col;
        bit last;
        bit ovf;
    } beat_t;

    logic                     clk = 1'b0;
    logic                     clear_n = 1'b0;
    logic                     unload_res = 1'b0;
    logic [1:0]               row_w = 2'd0;
    logic [1:0]               col_x = 2'd0;
    logic [MAC_NUM*RES_W-1:0] mac_res = '0;
    logic                     busy;
    logic                     done;

    mac_result_unloader_if rif ();

    mac_result_unloader dut (
        .clk        (clk),
        .clear_n    (clear_n),
        .mac_res    (mac_res),
        .unload_res (unload_res),
        .row_w      (row_w),
        .col_x      (col_x),
        .busy       (busy),
        .done       (done),
        .res        (rif)
    );

    int    vectors = 0;
    int    miscompares = 0;
    beat_t exp_q[$];
    int    done_pending = 0;
    int    ready_mode = 0;
    int    mac_vals[9];

    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endfunction

    function automatic void report_fail(string name, string detail);
        vectors++;
        miscompares++;
        $display("FAIL %s: %s", name, detail);
    endfunction

    // Reference: every element of the row_w x col_x sub-matrix, row-major.
    function automatic void push_model(int rw, int cx);
        beat_t e;
        for (int r = 0; r < rw; r++) begin
            for (int c = 0; c < cx; c++) begin
                int v = mac_vals[3*r + c];
`ifdef UNLOAD_CLIP_EN
                e.data = (v > 255) ? 255 : v;
                e.ovf  = (v > 255);
`else
                e.data = v;
                e.ovf  = 1'b0;
`endif
                e.row  = r;
                e.col  = c;
                e.last = (r == rw - 1) && (c == cx - 1);
                exp_q.push_back(e);
            end
        end
    endfunction

    // Consumer readiness: 0 always ready, 1 alternating, 2 random.
    initial begin
        rif.res_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       rif.res_ready = 1'b1;
                1:       rif.res_ready = ~rif.res_ready;
                default: rif.res_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    // Monitor: compares transferred beats, stall stability and done pulses.
    logic             stall_prev = 1'b0;
    logic [RES_W-1:0] hold_data;
    logic [1:0]       hold_row;
    logic [1:0]       hold_col;
    logic             hold_last;
    beat_t            mon_e;

    initial begin
        forever begin
            @(negedge clk);
            if (clear_n) begin
                if (stall_prev) begin
                    check("hold_data", rif.res_data, hold_data);
                    check("hold_row", rif.res_row, hold_row);
                    check("hold_col", rif.res_col, hold_col);
                    check("hold_last", rif.res_last, hold_last);
                end
                stall_prev = 1'b0;
                if (rif.res_valid === 1'b1) begin
                    if (rif.res_ready) begin
                        if (exp_q.size() == 0) begin
                            report_fail("unexpected_beat", $sformatf("data %0d with no beat expected", rif.res_data));
                        end else begin
                            mon_e = exp_q.pop_front();
                            check("beat_data", rif.res_data, mon_e.data);
                            check("beat_row", rif.res_row, mon_e.row);
                            check("beat_col", rif.res_col, mon_e.col);
                            check("beat_last", rif.res_last, mon_e.last);
`ifdef UNLOAD_CLIP_EN
                            check("beat_ovf", rif.res_ovf, mon_e.ovf);
`endif
                            $display("beat r%0d c%0d data %0d last %0d", rif.res_row, rif.res_col, rif.res_data, rif.res_last);
                        end
                    end else begin
                        stall_prev = 1'b1;
                        hold_data  = rif.res_data;
                        hold_row   = rif.res_row;
                        hold_col   = rif.res_col;
                        hold_last  = rif.res_last;
                    end
                end
                if (done === 1'b1) begin
                    if (done_pending == 0) begin
                        report_fail("unexpected_done", "done pulse with no job pending");
                    end else begin
                        check("beats_left_at_done", exp_q.size(), 0);
                        done_pending--;
                        $display("done");
                    end
                end
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    // Presents a job and returns just after the capturing clock edge.
    task automatic start_job(input int rw, input int cx);
        for (int k = 0; k < 9; k++) begin
            mac_res[k*RES_W +: RES_W] = RES_W'(mac_vals[k]);
        end
        row_w = 2'(rw);
        col_x = 2'(cx);
        push_model(rw, cx);
        done_pending++;
        unload_res = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Waits for the job to drain, keeps unload_res high a while (no retrigger), then drops it.
    task automatic finish_job();
        int n = 0;
        while ((exp_q.size() != 0 || done_pending != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            report_fail("job_timeout", $sformatf("%0d beats and %0d done left", exp_q.size(), done_pending));
            exp_q.delete();
            done_pending = 0;
        end
        repeat (5) @(posedge clk);
        #1;
        unload_res = 1'b0;
        @(posedge clk);
        #1;
    endtask

    function automatic void random_mac();
        for (int k = 0; k < 9; k++) begin
            case ($urandom_range(0, 5))
                0:       mac_vals[k] = 255;
                1:       mac_vals[k] = 256;
                2:       mac_vals[k] = 675;
                default: mac_vals[k] = $urandom_range(0, 675);
            endcase
        end
    endfunction

    initial begin
        int lat;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", rif.res_valid, 0);
        check("rst_data", rif.res_data, 0);
        check("rst_row", rif.res_row, 0);
        check("rst_col", rif.res_col, 0);
        check("rst_last", rif.res_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
`ifdef UNLOAD_CLIP_EN
        check("rst_ovf", rif.res_ovf, 0);
`endif
        @(posedge clk);
        #1;
        clear_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Full 3x3, MAC k = 10k, always ready: first beat right after the edge, done 9 cycles later
        ready_mode = 0;
        for (int k = 0; k < 9; k++) mac_vals[k] = 10 * k;
        start_job(3, 3);
        @(negedge clk);
        check("first_beat_valid", rif.res_valid, 1);
        check("first_beat_busy", busy, 1);
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("done_latency", lat, 9);
        finish_job();

        // 2x3 with alternating ready
        ready_mode = 1;
        random_mac();
        start_job(2, 3);
        finish_job();

        // Empty job: done and busy for one cycle only
        ready_mode = 0;
        random_mac();
        start_job(2, 0);
        @(negedge clk);
        check("empty_valid", rif.res_valid, 0);
        check("empty_busy", busy, 1);
        check("empty_done", done, 1);
        @(negedge clk);
        check("empty_busy_after", busy, 0);
        check("empty_done_after", done, 0);
        finish_job();

        // Clip boundaries
        random_mac();
        mac_vals[4] = 675;
        mac_vals[5] = 255;
        mac_vals[6] = 256;
        start_job(3, 3);
        finish_job();

        // Reset after the third transfer abandons the job
        ready_mode = 0;
        for (int k = 0; k < 9; k++) mac_vals[k] = 100 + k;
        start_job(3, 3);
        repeat (3) @(posedge clk);
        #1;
        clear_n = 1'b0;
        unload_res = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        done_pending = 0;
        @(negedge clk);
        check("abort_valid", rif.res_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_row", rif.res_row, 0);
        check("abort_col", rif.res_col, 0);
        check("abort_done", done, 0);
        @(posedge clk);
        #1;
        clear_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        start_job(3, 3);
        finish_job();

        // Inputs disturbed mid-stream plus a second unload_res edge: no effect
        ready_mode = 2;
        random_mac();
        start_job(3, 3);
        repeat (2) @(posedge clk);
        #1;
        mac_res = '0;
        row_w = 2'd1;
        col_x = 2'd1;
        unload_res = 1'b0;
        @(posedge clk);
        #1;
        unload_res = 1'b1;
        finish_job();

        // Randomized jobs
        for (int j = 0; j < 20; j++) begin
            ready_mode = $urandom_range(0, 2);
            random_mac();
            start_job($urandom_range(0, 3), $urandom_range(0, 3));
            finish_job();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
